// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types and helpers for the uio pad-bank arbiter.
// Combinational definitions only: no latency, no flow control.
// Backpressure is not applicable.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_e;

    localparam int MAX_REQ = 8;
    localparam int PAD_W   = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Requester-side and pad-side signal bundle of the uio arbiter.
// Pure wiring: no latency.
// Backpressure is level req/last from requesters, grant from the arbiter.
interface uio_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   last;
    logic [8*N_REQ-1:0] req_out;
    logic [8*N_REQ-1:0] req_oe;
    logic [7:0]         uio_in;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic [7:0]         uio_out;
    logic [7:0]         uio_oe;
    logic [7:0]         rd_data;
    logic [N_REQ-1:0]   timeout_err;

    modport slave (
        input  req, last, req_out, req_oe, uio_in,
        output grant, busy, uio_out, uio_oe, rd_data, timeout_err
    );

    modport master (
        output req, last, req_out, req_oe, uio_in,
        input  grant, busy, uio_out, uio_oe, rd_data, timeout_err
    );
endinterface

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld low when no request is pending.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             vld,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);
    int j;

    always_comb begin
        vld    = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!vld && req[j]) begin
                vld       = 1'b1;
                idx       = IDX_W'(j);
                onehot[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbiter for the shared uio pad bank; UIO_ARB_TIMEOUT_EN adds a forced release after MAX_HOLD cycles.
// Latency: req -> grant 1 cycle; owner drive -> pads 1 cycle; release -> next grant TURNAROUND+1 cycles.
// Backpressure: requesters hold req until granted; ownership ends on last, req drop or timeout.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 64
) (
    input  logic               clk,
    input  logic               rst,
    uio_bus_arbiter_if.slave   bus
);
    if (N_REQ < 2 || N_REQ > MAX_REQ || TURNAROUND < 1 || TURNAROUND > 15 ||
        MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_params
    end

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PAD_W-1:0]   uio_out_q, uio_out_d;
    logic [PAD_W-1:0]   uio_oe_q, uio_oe_d;
    logic [PAD_W-1:0]   rd_data_q, rd_data_d;
    logic [3:0]         turn_cnt_q, turn_cnt_d;
    logic [N_REQ-1:0]   timeout_err_q, timeout_err_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   owner;
    logic [PAD_W-1:0]   own_out, own_oe;
    logic               own_rel;
    logic               force_rel;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (rr_ptr_q),
        .vld    (pick_vld),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    assign owner   = onehot2idx(MAX_REQ'(grant_q));
    assign own_out = bus.req_out[int'(owner)*PAD_W +: PAD_W];
    assign own_oe  = bus.req_oe[int'(owner)*PAD_W +: PAD_W];
    assign own_rel = bus.last[owner] | ~bus.req[owner];

`ifdef UIO_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;

    assign force_rel = (hold_cnt_q == 8'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q == ST_IDLE && pick_vld) begin
            hold_cnt_d = '0;
        end else if (state_q == ST_OWN) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        uio_out_d     = uio_out_q;
        uio_oe_d      = '0;
        turn_cnt_d    = turn_cnt_q;
        timeout_err_d = '0;
        rd_data_d     = bus.uio_in;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_oh;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                uio_out_d = own_out;
                uio_oe_d  = own_oe;
                if (own_rel || force_rel) begin
                    // The release cycle's data still reaches the pad; only oe drops.
                    grant_d    = '0;
                    uio_oe_d   = '0;
                    rr_ptr_d   = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
                    turn_cnt_d = '0;
                    state_d    = ST_TURN;
                    if (!own_rel) begin
                        timeout_err_d = grant_q;
                    end
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == 4'(TURNAROUND - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            uio_out_q     <= '0;
            uio_oe_q      <= '0;
            rd_data_q     <= '0;
            turn_cnt_q    <= '0;
            timeout_err_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            uio_out_q     <= uio_out_d;
            uio_oe_q      <= uio_oe_d;
            rd_data_q     <= rd_data_d;
            turn_cnt_q    <= turn_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.uio_out     = uio_out_q;
    assign bus.uio_oe      = uio_oe_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
